// File: rtl/batch_mac_engine_pkg.sv
// Shared state encoding and mode constants for the batch MAC engine.
package batch_mac_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_INPUT  = 2'b01,
        S_EXEC   = 2'b10,
        S_OUTPUT = 2'b11
    } state_t;

    localparam logic MODE_PROD = 1'b0;
    localparam logic MODE_DOT  = 1'b1;

endpackage

// File: rtl/batch_mac_engine_if.sv
// Operand producer (REQ/ACK) and result consumer (VALID/RDY) bundle for the batch MAC engine.
interface batch_mac_engine_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1,
    parameter int X_W    = 2 * DATA_W + $clog2(DEPTH)
);
    logic              START;
    logic              MODE;
    logic [CNT_W-1:0]  LEN;
    logic              HALT;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              ACK;
    logic              REQ_AB;
    logic [X_W-1:0]    X;
    logic              X_VALID;
    logic              X_RDY;
    logic              BUSY;
    logic              DONE;

    modport master (
        output START, MODE, LEN, HALT, A, B, ACK, X_RDY,
        input  REQ_AB, X, X_VALID, BUSY, DONE
    );

    modport slave (
        input  START, MODE, LEN, HALT, A, B, ACK, X_RDY,
        output REQ_AB, X, X_VALID, BUSY, DONE
    );

endinterface

// File: rtl/batch_mac_engine_sync_fifo.sv
// Synchronous FIFO with first-word fall-through output (0 when empty) and a synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             WR,
    input  logic             RD,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             FULL,
    output logic             EMPTY
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign EMPTY = (wr_ptr == rd_ptr);
    assign FULL  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = RD && !EMPTY;
    assign wr_en = WR && (!FULL || rd_en);
    assign DOUT  = EMPTY ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en && !CLR) mem[wr_ptr[AW-1:0]] <= DIN;
    end

endmodule

// File: rtl/batch_mac_engine.sv
// Batch multiply engine: collects L operand pairs, then emits L products (MODE=0)
// or a single dot-product (MODE=1) through an output FIFO.
module batch_mac_engine
    import batch_mac_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1,
    parameter int X_W    = 2 * DATA_W + $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    batch_mac_engine_if.slave bus
);
    state_t              state;
    state_t              state_nxt;
    logic                mode_q;
    logic [CNT_W-1:0]    len_q;
    logic [CNT_W-1:0]    eff_len;
    logic [CNT_W-1:0]    in_cnt;
    logic [CNT_W-1:0]    rd_cnt;
    logic [CNT_W-1:0]    prod_cnt;
    logic [CNT_W-1:0]    out_cnt;
    logic [CNT_W-1:0]    out_total;
    logic [2*DATA_W-1:0] in_dout;
    logic [2*DATA_W-1:0] op_a;
    logic [2*DATA_W-1:0] op_b;
    logic [2*DATA_W-1:0] prod_q;
    logic                prod_v;
    logic [X_W-1:0]      prod_ext;
    logic [X_W-1:0]      acc;
    logic [X_W-1:0]      out_din;
    logic                in_full;
    logic                in_empty;
    logic                out_full;
    logic                out_empty;
    logic                req_ab;
    logic                in_wr;
    logic                in_rd;
    logic                out_wr;
    logic                out_rd;
    logic                last_prod;
    logic                done;

    assign eff_len   = (bus.LEN == '0 || bus.LEN > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.LEN;
    assign req_ab    = (state == S_INPUT) && (in_cnt < len_q) && !in_full;
    assign in_wr     = req_ab && bus.ACK;
    assign in_rd     = (state == S_EXEC) && (rd_cnt < len_q) && !in_empty;
    assign op_a      = {{DATA_W{1'b0}}, in_dout[2*DATA_W-1:DATA_W]};
    assign op_b      = {{DATA_W{1'b0}}, in_dout[DATA_W-1:0]};
    assign prod_ext  = {{(X_W-2*DATA_W){1'b0}}, prod_q};
    assign last_prod = prod_v && (prod_cnt == len_q - CNT_W'(1));

    // Dot mode pushes only once, folding the final product into the running sum.
    assign out_wr    = !out_full && ((mode_q == MODE_PROD) ? prod_v : last_prod);
    assign out_din   = (mode_q == MODE_PROD) ? prod_ext : (acc + prod_ext);
    assign out_total = (mode_q == MODE_DOT) ? CNT_W'(1) : len_q;
    assign out_rd    = (state == S_OUTPUT) && !out_empty && bus.X_RDY;
    assign done      = out_rd && (out_cnt == out_total - CNT_W'(1));

    assign bus.REQ_AB  = req_ab;
    assign bus.X_VALID = (state == S_OUTPUT) && !out_empty;
    assign bus.BUSY    = (state != S_IDLE);
    assign bus.DONE    = done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.START) state_nxt = S_INPUT;
            S_INPUT:  if (in_wr && in_cnt == len_q - CNT_W'(1)) state_nxt = S_EXEC;
            S_EXEC:   if (last_prod) state_nxt = S_OUTPUT;
            S_OUTPUT: if (done) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (bus.HALT) state_nxt = S_IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q   <= MODE_PROD;
            len_q    <= '0;
            in_cnt   <= '0;
            rd_cnt   <= '0;
            prod_cnt <= '0;
            out_cnt  <= '0;
            acc      <= '0;
            prod_q   <= '0;
            prod_v   <= 1'b0;
        end else if (bus.HALT) begin
            in_cnt   <= '0;
            rd_cnt   <= '0;
            prod_cnt <= '0;
            out_cnt  <= '0;
            acc      <= '0;
            prod_q   <= '0;
            prod_v   <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.START) begin
                mode_q   <= bus.MODE;
                len_q    <= eff_len;
                in_cnt   <= '0;
                rd_cnt   <= '0;
                prod_cnt <= '0;
                out_cnt  <= '0;
                acc      <= '0;
            end
            if (in_wr) in_cnt <= in_cnt + CNT_W'(1);
            if (in_rd) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
                prod_q <= op_a * op_b;
            end
            prod_v <= in_rd;
            if (prod_v) begin
                prod_cnt <= prod_cnt + CNT_W'(1);
                if (mode_q == MODE_DOT) acc <= acc + prod_ext;
            end
            if (out_rd) out_cnt <= out_cnt + CNT_W'(1);
        end
    end

    sync_fifo #(.WIDTH(2*DATA_W), .DEPTH(DEPTH)) u_in_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (bus.HALT),
        .WR    (in_wr),
        .RD    (in_rd),
        .DIN   ({bus.A, bus.B}),
        .DOUT  (in_dout),
        .FULL  (in_full),
        .EMPTY (in_empty)
    );

    sync_fifo #(.WIDTH(X_W), .DEPTH(DEPTH)) u_out_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (bus.HALT),
        .WR    (out_wr),
        .RD    (out_rd),
        .DIN   (out_din),
        .DOUT  (bus.X),
        .FULL  (out_full),
        .EMPTY (out_empty)
    );

endmodule

// File: tb/tb_batch_mac_engine.sv
// Randomized bench for batch_mac_engine; results are compared against a queue-based
// model of products and dot-products built from the accepted operand pairs.
module tb_batch_mac_engine;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int X_W    = 2 * DATA_W + $clog2(DEPTH);

    logic CLK;
    logic RST;
    int   check_count;
    int   pass_count;
    int   forced_a[$];
    int   forced_b[$];

    batch_mac_engine_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    batch_mac_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // One complete batch with the chosen ACK/X_RDY patterns; START may be re-poked while busy.
    task automatic applyStimulus(input bit mode, input logic [CNT_W-1:0] len,
                                 input int ack_mode, input int rdy_mode, input bit poke_start);
        int eff_l, hs, cyc, done_cnt, req_late, unstable, xv_cycles;
        int sum;
        bit finished, held;
        logic [X_W-1:0] held_x;
        int pa[$], pb[$], got_q[$], exp_q[$];

        eff_l = (len == 0 || len > DEPTH) ? DEPTH : int'(len);
        hs = 0; cyc = 0; done_cnt = 0; req_late = 0; unstable = 0; xv_cycles = 0;
        finished = 0; held = 0; held_x = '0;

        @(posedge CLK); #1;
        bus.START = 1'b1;
        bus.MODE  = mode;
        bus.LEN   = len;
        #1 checkOutput("idle_before_start", bus.BUSY, 0);
        @(posedge CLK); #1;
        bus.START = 1'b0;

        while (!finished && cyc < 400) begin
            case (ack_mode)
                0:       bus.ACK = 1'b1;
                1:       bus.ACK = (cyc % 2 == 0);
                default: bus.ACK = 1'($urandom_range(0, 1));
            endcase
            case (rdy_mode)
                0:       bus.X_RDY = 1'b1;
                1:       bus.X_RDY = (cyc % 3 == 0);
                default: bus.X_RDY = 1'($urandom_range(0, 1));
            endcase
            bus.A = (hs < forced_a.size()) ? 8'(forced_a[hs]) : 8'($urandom_range(0, 255));
            bus.B = (hs < forced_b.size()) ? 8'(forced_b[hs]) : 8'($urandom_range(0, 255));
            if (poke_start) begin
                bus.START = (cyc % 5 == 0);
                bus.MODE  = ~mode;
                bus.LEN   = len ^ 5'd7;
            end
            #1;
            if (hs >= eff_l && bus.REQ_AB) req_late++;
            if (bus.REQ_AB && bus.ACK) begin
                pa.push_back(int'(bus.A));
                pb.push_back(int'(bus.B));
                hs++;
            end
            if (held && (!bus.X_VALID || bus.X !== held_x)) unstable++;
            if (bus.X_VALID) xv_cycles++;
            if (bus.X_VALID && bus.X_RDY) got_q.push_back(int'(bus.X));
            held   = bus.X_VALID && !bus.X_RDY;
            held_x = bus.X;
            if (bus.DONE) begin
                done_cnt++;
                finished = 1;
            end
            @(posedge CLK); #1;
            cyc++;
        end

        bus.ACK = 1'b0; bus.X_RDY = 1'b0; bus.START = 1'b0;
        checkOutput("batch_finished", 32'(finished), 1);
        #1 checkOutput("busy_after_done", bus.BUSY, 0);
        repeat (3) begin
            if (bus.DONE) done_cnt++;
            @(posedge CLK); #1;
        end
        if (!finished) begin
            bus.HALT = 1'b1;
            @(posedge CLK); #1;
            bus.HALT = 1'b0;
        end

        if (mode == 1'b0) begin
            foreach (pa[i]) exp_q.push_back(pa[i] * pb[i]);
        end else begin
            sum = 0;
            foreach (pa[i]) sum += pa[i] * pb[i];
            exp_q.push_back(sum);
        end

        checkOutput("handshakes", hs, eff_l);
        checkOutput("req_after_last", req_late, 0);
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("hold_stable", unstable, 0);
        checkOutput("result_count", got_q.size(), exp_q.size());
        if (rdy_mode == 0) checkOutput("xvalid_cycles", xv_cycles, exp_q.size());
        foreach (exp_q[i])
            if (i < got_q.size()) checkOutput($sformatf("result_%0d", i), got_q[i], exp_q[i]);

        forced_a.delete();
        forced_b.delete();
    endtask

    initial begin
        int wait_cyc, bad;
        check_count = 0;
        pass_count  = 0;
        RST = 1'b1;
        bus.START = 0; bus.MODE = 0; bus.LEN = '0; bus.HALT = 0;
        bus.A = '0; bus.B = '0; bus.ACK = 0; bus.X_RDY = 0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_req", bus.REQ_AB, 0);
        checkOutput("reset_xvalid", bus.X_VALID, 0);
        checkOutput("reset_x", bus.X, 0);
        checkOutput("reset_busy", bus.BUSY, 0);
        checkOutput("reset_done", bus.DONE, 0);
        RST = 1'b0;

        $display("[TB] element-wise products with fixed pairs");
        forced_a = '{3, 255, 0};
        forced_b = '{4, 255, 7};
        applyStimulus(1'b0, 5'd3, 0, 0, 1'b0);

        $display("[TB] full-depth dot product of 255*255");
        for (int i = 0; i < DEPTH; i++) begin
            forced_a.push_back(255);
            forced_b.push_back(255);
        end
        applyStimulus(1'b1, 5'd0, 0, 0, 1'b0);

        $display("[TB] toggling ACK with a slow consumer");
        applyStimulus(1'b0, 5'd4, 1, 1, 1'b0);

        $display("[TB] HALT during EXEC");
        @(posedge CLK); #1;
        bus.START = 1; bus.MODE = 1; bus.LEN = 5'd2;
        @(posedge CLK); #1;
        bus.START = 0; bus.ACK = 1; bus.A = 8'd10; bus.B = 8'd10;
        #1 checkOutput("halt_req_first", bus.REQ_AB, 1);
        @(posedge CLK); #1;
        bus.A = 8'd2; bus.B = 8'd3;
        #1 checkOutput("halt_req_second", bus.REQ_AB, 1);
        @(posedge CLK); #1;
        bus.ACK = 0;
        #1 checkOutput("halt_busy_exec", bus.BUSY, 1);
        checkOutput("halt_req_exec", bus.REQ_AB, 0);
        @(posedge CLK); #1;
        bus.HALT = 1;
        @(posedge CLK); #1;
        bus.HALT = 0;
        #1 checkOutput("halt_busy_after", bus.BUSY, 0);
        bad = 0;
        repeat (4) begin
            if (bus.X_VALID || bus.DONE) bad++;
            @(posedge CLK); #1;
        end
        checkOutput("halt_no_output", bad, 0);
        forced_a = '{1};
        forced_b = '{1};
        applyStimulus(1'b1, 5'd1, 0, 0, 1'b0);

        $display("[TB] asynchronous reset with results pending");
        @(posedge CLK); #1;
        bus.START = 1; bus.MODE = 0; bus.LEN = 5'd3;
        @(posedge CLK); #1;
        bus.START = 0; bus.ACK = 1; bus.A = 8'd5; bus.B = 8'd3; bus.X_RDY = 0;
        wait_cyc = 0;
        #1;
        while (!bus.X_VALID && wait_cyc < 50) begin
            @(posedge CLK); #1;
            wait_cyc++;
        end
        bus.ACK = 0;
        checkOutput("rst_setup_valid", bus.X_VALID, 1);
        bus.X_RDY = 1;
        #1 checkOutput("rst_first_pop", bus.X, 15);
        @(posedge CLK); #1;
        bus.X_RDY = 0;
        #1 checkOutput("rst_pending_valid", bus.X_VALID, 1);
        #2 RST = 1;
        #1;
        checkOutput("rst_xvalid", bus.X_VALID, 0);
        checkOutput("rst_x", bus.X, 0);
        checkOutput("rst_busy", bus.BUSY, 0);
        checkOutput("rst_done", bus.DONE, 0);
        checkOutput("rst_req", bus.REQ_AB, 0);
        @(posedge CLK); #1;
        RST = 0;
        applyStimulus(1'b0, 5'd6, 2, 2, 1'b0);

        $display("[TB] START re-asserted while busy");
        applyStimulus(1'b0, 5'd5, 0, 2, 1'b1);

        $display("[TB] random batches");
        for (int n = 0; n < 6; n++)
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 2, 2, 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
